// File: rtl/vectrex_cart_loader_if.sv
// Cart memory write port between the cartridge loader and the SDRAM controller.
// The loader drives request/address/data; the memory side answers with a one-cycle ack.
interface vectrex_cart_loader_if;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_ack;

  modport master (output mem_req, output mem_addr, output mem_din, input mem_ack);
  modport slave  (input mem_req, input mem_addr, input mem_din, output mem_ack);
endinterface

// File: rtl/vectrex_cart_loader.sv
// Queues ioctl cartridge bytes into a 2-entry FIFO feeding cart memory, and sequences
// the Vectrex core reset (power-on, user, post-download and optional skip-logo reset).
module vectrex_cart_loader #(
  parameter int RESET_CYCLES = 1000,
  parameter int LOGO_DELAY   = 5000000
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  input  logic                  user_reset,
  input  logic                  skip_logo,
  vectrex_cart_loader_if.master mem,
  output logic                  core_reset,
  output logic                  loading,
  output logic [15:0]           cart_size,
  output logic                  overflow
);
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_HOLD, ST_LOGO_WAIT} state_t;
  typedef enum logic [1:0] {TAG_USER, TAG_POST, TAG_SECOND} tag_t;

  localparam logic [31:0] RESET_LOAD = 32'(RESET_CYCLES);
  localparam logic [31:0] LOGO_LOAD  = 32'(LOGO_DELAY);

  state_t      state_reg, state_next;
  tag_t        tag_reg, tag_next;
  logic [31:0] cnt_reg, cnt_next;
  logic        dl_reg;
  logic        core_reset_reg, loading_reg;
  logic [15:0] cart_size_reg, cart_size_next;
  logic        overflow_reg, overflow_next;

  // FIFO is a head register (drives the memory port directly) plus one spare slot
  logic        head_valid_reg, head_valid_next;
  logic [14:0] head_addr_reg, head_addr_next;
  logic [7:0]  head_data_reg, head_data_next;
  logic        tail_valid_reg, tail_valid_next;
  logic [14:0] tail_addr_reg, tail_addr_next;
  logic [7:0]  tail_data_reg, tail_data_next;

  logic        dl_rise, dl_fall, pop, wr_in_load, in_range, push, drop;
  logic [15:0] addr_plus1;

  assign dl_rise    = ioctl_download & ~dl_reg;
  assign dl_fall    = ~ioctl_download & dl_reg;
  assign pop        = head_valid_reg & mem.mem_ack;
  assign wr_in_load = (state_reg == ST_LOAD) & ioctl_wr;
  assign in_range   = (ioctl_addr[24:15] == 10'd0);
  assign push       = wr_in_load & in_range & (~tail_valid_reg | pop);
  assign drop       = wr_in_load & ~push;
  assign addr_plus1 = {1'b0, ioctl_addr[14:0]} + 16'd1;

  always_comb begin
    head_valid_next = head_valid_reg;
    head_addr_next  = head_addr_reg;
    head_data_next  = head_data_reg;
    tail_valid_next = tail_valid_reg;
    tail_addr_next  = tail_addr_reg;
    tail_data_next  = tail_data_reg;
    if (dl_rise) begin
      head_valid_next = 1'b0;
      tail_valid_next = 1'b0;
    end else if (pop) begin
      if (tail_valid_reg) begin
        head_addr_next = tail_addr_reg;
        head_data_next = tail_data_reg;
        if (push) begin
          tail_addr_next = ioctl_addr[14:0];
          tail_data_next = ioctl_dout;
        end else begin
          tail_valid_next = 1'b0;
        end
      end else if (push) begin
        head_addr_next = ioctl_addr[14:0];
        head_data_next = ioctl_dout;
      end else begin
        head_valid_next = 1'b0;
      end
    end else if (push) begin
      if (head_valid_reg) begin
        tail_valid_next = 1'b1;
        tail_addr_next  = ioctl_addr[14:0];
        tail_data_next  = ioctl_dout;
      end else begin
        head_valid_next = 1'b1;
        head_addr_next  = ioctl_addr[14:0];
        head_data_next  = ioctl_dout;
      end
    end
  end

  always_comb begin
    cart_size_next = cart_size_reg;
    overflow_next  = overflow_reg;
    if (dl_rise) begin
      cart_size_next = 16'd0;
      overflow_next  = 1'b0;
    end else begin
      if (drop)
        overflow_next = 1'b1;
      if (push && (addr_plus1 > cart_size_reg))
        cart_size_next = addr_plus1;
    end
  end

  // Priority: download start, then user reset (outside LOAD/DRAIN), then countdowns
  always_comb begin
    state_next = state_reg;
    tag_next   = tag_reg;
    cnt_next   = cnt_reg;
    if (dl_rise) begin
      state_next = ST_LOAD;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          if (dl_fall)
            state_next = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!head_valid_reg) begin
            state_next = ST_HOLD;
            tag_next   = TAG_POST;
            cnt_next   = RESET_LOAD;
          end
        end
        default: begin
          if (user_reset) begin
            state_next = ST_HOLD;
            tag_next   = TAG_USER;
            cnt_next   = RESET_LOAD;
          end else if (state_reg == ST_HOLD) begin
            if (cnt_reg <= 32'd1) begin
              if ((tag_reg == TAG_POST) && skip_logo) begin
                state_next = ST_LOGO_WAIT;
                cnt_next   = LOGO_LOAD;
              end else begin
                state_next = ST_IDLE;
              end
            end else begin
              cnt_next = cnt_reg - 32'd1;
            end
          end else if (state_reg == ST_LOGO_WAIT) begin
            if (cnt_reg <= 32'd1) begin
              state_next = ST_HOLD;
              tag_next   = TAG_SECOND;
              cnt_next   = RESET_LOAD;
            end else begin
              cnt_next = cnt_reg - 32'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_HOLD;
      tag_reg        <= TAG_USER;
      cnt_reg        <= RESET_LOAD;
      dl_reg         <= 1'b0;
      core_reset_reg <= 1'b1;
      loading_reg    <= 1'b0;
      cart_size_reg  <= 16'd0;
      overflow_reg   <= 1'b0;
      head_valid_reg <= 1'b0;
      head_addr_reg  <= 15'd0;
      head_data_reg  <= 8'd0;
      tail_valid_reg <= 1'b0;
      tail_addr_reg  <= 15'd0;
      tail_data_reg  <= 8'd0;
    end else begin
      state_reg      <= state_next;
      tag_reg        <= tag_next;
      cnt_reg        <= cnt_next;
      dl_reg         <= ioctl_download;
      core_reset_reg <= (state_next != ST_IDLE) && (state_next != ST_LOGO_WAIT);
      loading_reg    <= (state_next == ST_LOAD) || (state_next == ST_DRAIN);
      cart_size_reg  <= cart_size_next;
      overflow_reg   <= overflow_next;
      head_valid_reg <= head_valid_next;
      head_addr_reg  <= head_addr_next;
      head_data_reg  <= head_data_next;
      tail_valid_reg <= tail_valid_next;
      tail_addr_reg  <= tail_addr_next;
      tail_data_reg  <= tail_data_next;
    end
  end

  assign mem.mem_req  = head_valid_reg;
  assign mem.mem_addr = head_addr_reg;
  assign mem.mem_din  = head_data_reg;
  assign core_reset   = core_reset_reg;
  assign loading      = loading_reg;
  assign cart_size    = cart_size_reg;
  assign overflow     = overflow_reg;

endmodule

// File: tb/tb_vectrex_cart_loader.sv
// Directed bench for vectrex_cart_loader with RESET_CYCLES=8 and LOGO_DELAY=20.
module tb_vectrex_cart_loader;
  localparam int RC = 8;
  localparam int LD = 20;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        user_reset;
  logic        skip_logo;
  logic        core_reset;
  logic        loading;
  logic [15:0] cart_size;
  logic        overflow;

  int vec_count = 0;
  int err_count = 0;

  vectrex_cart_loader_if mem_bus ();

  vectrex_cart_loader #(.RESET_CYCLES(RC), .LOGO_DELAY(LD)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .user_reset     (user_reset),
    .skip_logo      (skip_logo),
    .mem            (mem_bus),
    .core_reset     (core_reset),
    .loading        (loading),
    .cart_size      (cart_size),
    .overflow       (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    logic exp_rst;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_dout = '0; user_reset = 1'b0; skip_logo = 1'b0; mem_bus.mem_ack = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    vec_count++;
    if (core_reset !== 1'b1 || loading !== 1'b0 || cart_size !== 16'd0 || overflow !== 1'b0) begin
      err_count++;
      $display("FAIL reset_vals: core_reset=%b loading=%b cart_size=%h overflow=%b, want 1 0 0000 0",
               core_reset, loading, cart_size, overflow);
    end
    vec_count++;
    if (mem_bus.mem_req !== 1'b0 || mem_bus.mem_addr !== 15'd0 || mem_bus.mem_din !== 8'd0) begin
      err_count++;
      $display("FAIL reset_mem: req=%b addr=%h din=%h, want 0 0000 00",
               mem_bus.mem_req, mem_bus.mem_addr, mem_bus.mem_din);
    end
    reset_n = 1'b1;
    for (int k = 0; k <= RC; k++) begin
      if (k > 0) tick();
      exp_rst = (k < RC) ? 1'b1 : 1'b0;
      vec_count++;
      if (core_reset !== exp_rst || mem_bus.mem_req !== 1'b0) begin
        err_count++;
        $display("FAIL power_on cycle %0d: core_reset=%b req=%b, want %b 0",
                 k, core_reset, mem_bus.mem_req, exp_rst);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_download();
    logic [7:0]  exp_d;
    logic [14:0] exp_a;
    mem_bus.mem_ack = 1'b1;
    ioctl_download = 1'b1;
    tick();
    vec_count++;
    if (loading !== 1'b1 || core_reset !== 1'b1) begin
      err_count++;
      $display("FAIL dl_start: loading=%b core_reset=%b, want 1 1", loading, core_reset);
    end
    for (int i = 0; i < 4; i++) begin
      exp_a = 15'(i);
      exp_d = 8'(8'hA0 + i);
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = exp_d;
      tick();
      vec_count++;
      if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== exp_a || mem_bus.mem_din !== exp_d) begin
        err_count++;
        $display("FAIL dl_beat %0d: req=%b addr=%h din=%h, want 1 %h %h",
                 i, mem_bus.mem_req, mem_bus.mem_addr, mem_bus.mem_din, exp_a, exp_d);
      end
    end
    ioctl_wr = 1'b0;
    tick();
    vec_count++;
    if (mem_bus.mem_req !== 1'b0 || cart_size !== 16'd4 || overflow !== 1'b0) begin
      err_count++;
      $display("FAIL dl_done: req=%b cart_size=%h overflow=%b, want 0 0004 0",
               mem_bus.mem_req, cart_size, overflow);
    end
    ioctl_download = 1'b0;
    tick();
    vec_count++;
    if (loading !== 1'b1 || core_reset !== 1'b1) begin
      err_count++;
      $display("FAIL drain: loading=%b core_reset=%b, want 1 1", loading, core_reset);
    end
    for (int k = 0; k < RC; k++) begin
      tick();
      vec_count++;
      if (core_reset !== 1'b1 || loading !== 1'b0) begin
        err_count++;
        $display("FAIL post_hold cycle %0d: core_reset=%b loading=%b, want 1 0", k, core_reset, loading);
      end
    end
    tick();
    vec_count++;
    if (core_reset !== 1'b0) begin
      err_count++;
      $display("FAIL post_idle: core_reset=%b, want 0", core_reset);
    end
    $display("test_download done");
  endtask

  task automatic test_back_pressure();
    int writes;
    mem_bus.mem_ack = 1'b0;
    ioctl_download = 1'b1;
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'd10; ioctl_dout = 8'h55;
    tick();
    vec_count++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 15'd10 || mem_bus.mem_din !== 8'h55 || overflow !== 1'b0) begin
      err_count++;
      $display("FAIL bp_first: req=%b addr=%h din=%h ovf=%b, want 1 000a 55 0",
               mem_bus.mem_req, mem_bus.mem_addr, mem_bus.mem_din, overflow);
    end
    ioctl_addr = 25'd11; ioctl_dout = 8'h66;
    tick();
    vec_count++;
    if (mem_bus.mem_addr !== 15'd10 || mem_bus.mem_din !== 8'h55 || overflow !== 1'b0) begin
      err_count++;
      $display("FAIL bp_second: addr=%h din=%h ovf=%b, want 000a 55 0",
               mem_bus.mem_addr, mem_bus.mem_din, overflow);
    end
    ioctl_addr = 25'd12; ioctl_dout = 8'h77;
    tick();
    vec_count++;
    if (mem_bus.mem_addr !== 15'd10 || mem_bus.mem_din !== 8'h55 || overflow !== 1'b1) begin
      err_count++;
      $display("FAIL bp_drop: addr=%h din=%h ovf=%b, want 000a 55 1",
               mem_bus.mem_addr, mem_bus.mem_din, overflow);
    end
    ioctl_wr = 1'b0;
    repeat (3) tick();
    vec_count++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 15'd10 || mem_bus.mem_din !== 8'h55) begin
      err_count++;
      $display("FAIL bp_stable: req=%b addr=%h din=%h, want 1 000a 55",
               mem_bus.mem_req, mem_bus.mem_addr, mem_bus.mem_din);
    end
    mem_bus.mem_ack = 1'b1;
    writes = 0;
    for (int k = 0; k < 4; k++) begin
      if (mem_bus.mem_req === 1'b1) begin
        vec_count++;
        if (mem_bus.mem_addr !== 15'(10 + writes)) begin
          err_count++;
          $display("FAIL bp_order %0d: addr=%h, want %h", writes, mem_bus.mem_addr, 15'(10 + writes));
        end
        writes++;
      end
      tick();
    end
    mem_bus.mem_ack = 1'b0;
    vec_count++;
    if (writes !== 2 || cart_size !== 16'd12) begin
      err_count++;
      $display("FAIL bp_writes: writes=%0d cart_size=%h, want 2 000c", writes, cart_size);
    end
    ioctl_download = 1'b0;
    repeat (RC + 2) tick();
    vec_count++;
    if (core_reset !== 1'b0) begin
      err_count++;
      $display("FAIL bp_end: core_reset=%b, want 0", core_reset);
    end
    $display("test_back_pressure done");
  endtask

  task automatic test_out_of_range();
    mem_bus.mem_ack = 1'b1;
    ioctl_download = 1'b1;
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'h8000; ioctl_dout = 8'h11;
    tick();
    vec_count++;
    if (mem_bus.mem_req !== 1'b0 || overflow !== 1'b1 || cart_size !== 16'd0) begin
      err_count++;
      $display("FAIL oor_drop: req=%b ovf=%b cart_size=%h, want 0 1 0000",
               mem_bus.mem_req, overflow, cart_size);
    end
    ioctl_addr = 25'h7FFF; ioctl_dout = 8'h22;
    tick();
    vec_count++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 15'h7FFF || mem_bus.mem_din !== 8'h22 || cart_size !== 16'h8000) begin
      err_count++;
      $display("FAIL oor_top: req=%b addr=%h din=%h cart_size=%h, want 1 7fff 22 8000",
               mem_bus.mem_req, mem_bus.mem_addr, mem_bus.mem_din, cart_size);
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    repeat (RC + 3) tick();
    vec_count++;
    if (mem_bus.mem_req !== 1'b0 || cart_size !== 16'h8000 || overflow !== 1'b1 || core_reset !== 1'b0) begin
      err_count++;
      $display("FAIL oor_hold: req=%b cart_size=%h ovf=%b core_reset=%b, want 0 8000 1 0",
               mem_bus.mem_req, cart_size, overflow, core_reset);
    end
    $display("test_out_of_range done");
  endtask

  task automatic test_skip_logo();
    logic exp_rst;
    skip_logo = 1'b1;
    ioctl_download = 1'b1;
    tick();
    ioctl_download = 1'b0;
    tick();
    for (int t = 1; t <= 2 * RC + LD + 4; t++) begin
      tick();
      exp_rst = ((t <= RC) || (t > RC + LD && t <= 2 * RC + LD)) ? 1'b1 : 1'b0;
      vec_count++;
      if (core_reset !== exp_rst) begin
        err_count++;
        $display("FAIL skip_logo cycle %0d: core_reset=%b, want %b", t, core_reset, exp_rst);
      end
    end
    $display("test_skip_logo done");
  endtask

  task automatic test_user_reset_logo();
    skip_logo = 1'b1;
    ioctl_download = 1'b1;
    tick();
    ioctl_download = 1'b0;
    tick();
    repeat (RC + 5) tick();
    vec_count++;
    if (core_reset !== 1'b0) begin
      err_count++;
      $display("FAIL ur_logo_wait: core_reset=%b, want 0", core_reset);
    end
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    vec_count++;
    if (core_reset !== 1'b1) begin
      err_count++;
      $display("FAIL ur_start: core_reset=%b, want 1", core_reset);
    end
    for (int k = 1; k < RC; k++) begin
      tick();
      vec_count++;
      if (core_reset !== 1'b1) begin
        err_count++;
        $display("FAIL ur_pulse cycle %0d: core_reset=%b, want 1", k, core_reset);
      end
    end
    for (int k = 0; k < LD + RC + 2; k++) begin
      tick();
      vec_count++;
      if (core_reset !== 1'b0) begin
        err_count++;
        $display("FAIL ur_no_second cycle %0d: core_reset=%b, want 0", k, core_reset);
      end
    end
    skip_logo = 1'b0;
    $display("test_user_reset_logo done");
  endtask

  task automatic test_dl_in_logo();
    skip_logo = 1'b1;
    mem_bus.mem_ack = 1'b1;
    ioctl_download = 1'b1;
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'h10000; ioctl_dout = 8'h01;
    tick();
    ioctl_addr = 25'd5; ioctl_dout = 8'h3C;
    tick();
    ioctl_wr = 1'b0;
    tick();
    vec_count++;
    if (cart_size !== 16'd6 || overflow !== 1'b1) begin
      err_count++;
      $display("FAIL dlw_setup: cart_size=%h ovf=%b, want 0006 1", cart_size, overflow);
    end
    ioctl_download = 1'b0;
    tick();
    repeat (RC + 3) tick();
    vec_count++;
    if (core_reset !== 1'b0 || loading !== 1'b0) begin
      err_count++;
      $display("FAIL dlw_logo: core_reset=%b loading=%b, want 0 0", core_reset, loading);
    end
    ioctl_download = 1'b1;
    tick();
    vec_count++;
    if (loading !== 1'b1 || core_reset !== 1'b1 || cart_size !== 16'd0 || overflow !== 1'b0) begin
      err_count++;
      $display("FAIL dlw_restart: loading=%b core_reset=%b cart_size=%h ovf=%b, want 1 1 0000 0",
               loading, core_reset, cart_size, overflow);
    end
    skip_logo = 1'b0;
    ioctl_download = 1'b0;
    repeat (RC + 2) tick();
    vec_count++;
    if (core_reset !== 1'b0 || loading !== 1'b0) begin
      err_count++;
      $display("FAIL dlw_end: core_reset=%b loading=%b, want 0 0", core_reset, loading);
    end
    $display("test_dl_in_logo done");
  endtask

  task automatic test_async_reset();
    mem_bus.mem_ack = 1'b0;
    ioctl_download = 1'b1;
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'd3; ioctl_dout = 8'h99;
    tick();
    ioctl_wr = 1'b0;
    vec_count++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_din !== 8'h99) begin
      err_count++;
      $display("FAIL ar_pending: req=%b din=%h, want 1 99", mem_bus.mem_req, mem_bus.mem_din);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vec_count++;
    if (core_reset !== 1'b1 || mem_bus.mem_req !== 1'b0 || loading !== 1'b0 || cart_size !== 16'd0 ||
        mem_bus.mem_addr !== 15'd0 || mem_bus.mem_din !== 8'd0) begin
      err_count++;
      $display("FAIL ar_values: core_reset=%b req=%b loading=%b cart_size=%h addr=%h din=%h, want 1 0 0 0000 0000 00",
               core_reset, mem_bus.mem_req, loading, cart_size, mem_bus.mem_addr, mem_bus.mem_din);
    end
    ioctl_download = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (RC) tick();
    vec_count++;
    if (core_reset !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
      err_count++;
      $display("FAIL ar_recover: core_reset=%b req=%b, want 0 0", core_reset, mem_bus.mem_req);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_download();
    test_back_pressure();
    test_out_of_range();
    test_skip_logo();
    test_user_reset_logo();
    test_dl_in_logo();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end
endmodule
